// File: rtl/id_ex_stage_pkg.sv
// Shared types and constants for the ID/EX pipeline register and its hazard logic.
package id_ex_stage_pkg;

  localparam int unsigned ALUOP_W = 4;
  localparam int unsigned CNT_W   = 16;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_BUBBLE = 2'd1,
    ST_FROZEN = 2'd2
  } state_t;

  typedef struct packed {
    logic               reg_write;
    logic               mem_read;
    logic               mem_write;
    logic               mem_to_reg;
    logic               reg_dst;
    logic               read_sp;
    logic               alu_src;
    logic               valid;
    logic [ALUOP_W-1:0] alu_op;
  } ctrl_t;

  // A bubble carries no side effects; every control bit is cleared.
  localparam ctrl_t BUBBLE_CTRL = '0;

endpackage

// File: rtl/id_ex_stage_hazard_detect.sv
// Combinational load-use and branch-in-ID hazard detection; r0 never creates a hazard.
module hazard_detect #(
  parameter int unsigned REG_W = 5
) (
  input  logic [REG_W-1:0] i_if_id_rs,
  input  logic [REG_W-1:0] i_if_id_rt,
  input  logic             i_id_branch,
  input  logic             i_id_valid,
  input  logic [REG_W-1:0] i_id_ex_dest,
  input  logic             i_id_ex_mem_read,
  input  logic             i_id_ex_reg_write,
  input  logic [REG_W-1:0] i_ex_mem_rd,
  input  logic             i_ex_mem_mem_read,
  output logic             o_lu,
  output logic             o_br_ex,
  output logic             o_br_mem,
  output logic             o_stall
);

  logic w_ex_match;
  logic w_mem_match;

  assign w_ex_match  = (i_id_ex_dest != '0) &&
                       ((i_id_ex_dest == i_if_id_rs) || (i_id_ex_dest == i_if_id_rt));
  assign w_mem_match = (i_ex_mem_rd != '0) &&
                       ((i_ex_mem_rd == i_if_id_rs) || (i_ex_mem_rd == i_if_id_rt));

  assign o_lu     = i_id_ex_mem_read && w_ex_match;
  assign o_br_ex  = i_id_branch && i_id_ex_reg_write && w_ex_match;
  assign o_br_mem = i_id_branch && i_ex_mem_mem_read && w_mem_match;
  assign o_stall  = i_id_valid && (o_lu || o_br_ex || o_br_mem);

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with stall/bubble/freeze control and a saturating stall counter.
module id_ex_stage
  import id_ex_stage_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned REG_W  = 5
) (
  input  logic               Clk,
  input  logic               Rst,
  input  logic [REG_W-1:0]   If_Id_Rs,
  input  logic [REG_W-1:0]   If_Id_Rt,
  input  logic [REG_W-1:0]   Id_Rd,
  input  logic [DATA_W-1:0]  Id_ReadData1,
  input  logic [DATA_W-1:0]  Id_ReadData2,
  input  logic [DATA_W-1:0]  Id_Imm,
  input  logic               Id_RegWrite,
  input  logic               Id_MemRead,
  input  logic               Id_MemWrite,
  input  logic               Id_MemToReg,
  input  logic               Id_RegDst,
  input  logic               Id_ReadSp,
  input  logic               Id_ALUSrc,
  input  logic               Id_Branch,
  input  logic               Id_Valid,
  input  logic [ALUOP_W-1:0] Id_ALUOp,
  input  logic [REG_W-1:0]   Ex_Mem_Rd,
  input  logic               Ex_Mem_MemRead,
  input  logic               Flush,
  input  logic               Mem_Busy,
  output logic [REG_W-1:0]   Id_Ex_Rs,
  output logic [REG_W-1:0]   Id_Ex_Rt,
  output logic [REG_W-1:0]   Id_Ex_Dest,
  output logic [DATA_W-1:0]  Id_Ex_ReadData1,
  output logic [DATA_W-1:0]  Id_Ex_ReadData2,
  output logic [DATA_W-1:0]  Id_Ex_Imm,
  output logic               Id_Ex_RegWrite,
  output logic               Id_Ex_MemRead,
  output logic               Id_Ex_MemWrite,
  output logic               Id_Ex_MemToReg,
  output logic               Id_Ex_RegDst,
  output logic               Id_Ex_ReadSp,
  output logic               Id_Ex_ALUSrc,
  output logic               Id_Ex_Valid,
  output logic [ALUOP_W-1:0] Id_Ex_ALUOp,
  output logic               PC_Write,
  output logic               If_Id_Write,
  output logic [CNT_W-1:0]   Stall_Count
);

  state_t              r_state;
  ctrl_t               r_ctrl;
  logic [REG_W-1:0]    r_rs;
  logic [REG_W-1:0]    r_rt;
  logic [REG_W-1:0]    r_dest;
  logic [DATA_W-1:0]   r_rd1;
  logic [DATA_W-1:0]   r_rd2;
  logic [DATA_W-1:0]   r_imm;
  logic [CNT_W-1:0]    r_stall_cnt;

  ctrl_t               w_id_ctrl;
  logic                w_lu;
  logic                w_br_ex;
  logic                w_br_mem;
  logic                w_stall;
  logic                w_hold;

  always_comb begin
    w_id_ctrl            = BUBBLE_CTRL;
    w_id_ctrl.reg_write  = Id_RegWrite;
    w_id_ctrl.mem_read   = Id_MemRead;
    w_id_ctrl.mem_write  = Id_MemWrite;
    w_id_ctrl.mem_to_reg = Id_MemToReg;
    w_id_ctrl.reg_dst    = Id_RegDst;
    w_id_ctrl.read_sp    = Id_ReadSp;
    w_id_ctrl.alu_src    = Id_ALUSrc;
    w_id_ctrl.valid      = Id_Valid;
    w_id_ctrl.alu_op     = Id_ALUOp;
  end

  hazard_detect #(
    .REG_W (REG_W)
  ) u_hazard_detect (
    .i_if_id_rs        (If_Id_Rs),
    .i_if_id_rt        (If_Id_Rt),
    .i_id_branch       (Id_Branch),
    .i_id_valid        (Id_Valid),
    .i_id_ex_dest      (r_dest),
    .i_id_ex_mem_read  (r_ctrl.mem_read),
    .i_id_ex_reg_write (r_ctrl.reg_write),
    .i_ex_mem_rd       (Ex_Mem_Rd),
    .i_ex_mem_mem_read (Ex_Mem_MemRead),
    .o_lu              (w_lu),
    .o_br_ex           (w_br_ex),
    .o_br_mem          (w_br_mem),
    .o_stall           (w_stall)
  );

  assign w_hold      = w_stall || Mem_Busy;
  assign PC_Write    = ~w_hold;
  assign If_Id_Write = ~w_hold;

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      r_state     <= ST_RUN;
      r_ctrl      <= BUBBLE_CTRL;
      r_rs        <= '0;
      r_rt        <= '0;
      r_dest      <= '0;
      r_rd1       <= '0;
      r_rd2       <= '0;
      r_imm       <= '0;
      r_stall_cnt <= '0;
    end else begin
      if (Mem_Busy)     r_state <= ST_FROZEN;
      else if (w_stall) r_state <= ST_BUBBLE;
      else              r_state <= ST_RUN;

      // Mem_Busy freezes every field, including the stall counter.
      if (!Mem_Busy) begin
        if (Flush || w_stall) begin
          r_ctrl <= BUBBLE_CTRL;
          r_rs   <= '0;
          r_rt   <= '0;
          r_dest <= '0;
          r_rd1  <= '0;
          r_rd2  <= '0;
          r_imm  <= '0;
        end else begin
          r_ctrl <= w_id_ctrl;
          r_rs   <= If_Id_Rs;
          r_rt   <= If_Id_Rt;
          r_dest <= Id_RegDst ? Id_Rd : If_Id_Rt;
          r_rd1  <= Id_ReadData1;
          r_rd2  <= Id_ReadData2;
          r_imm  <= Id_Imm;
        end
        if (w_stall && (r_stall_cnt != '1)) r_stall_cnt <= r_stall_cnt + 1'b1;
      end
    end
  end

  a_frozen: assert property (@(posedge Clk) disable iff (Rst)
    Mem_Busy |=> (r_state == ST_FROZEN));
  a_bubble: assert property (@(posedge Clk) disable iff (Rst)
    (w_stall && !Mem_Busy) |=> (r_state == ST_BUBBLE && !r_ctrl.valid));
  a_hold: assert property (@(posedge Clk) disable iff (Rst)
    (Id_Valid && (w_lu || w_br_ex || w_br_mem)) |-> !PC_Write);

  assign Id_Ex_Rs        = r_rs;
  assign Id_Ex_Rt        = r_rt;
  assign Id_Ex_Dest      = r_dest;
  assign Id_Ex_ReadData1 = r_rd1;
  assign Id_Ex_ReadData2 = r_rd2;
  assign Id_Ex_Imm       = r_imm;
  assign Id_Ex_RegWrite  = r_ctrl.reg_write;
  assign Id_Ex_MemRead   = r_ctrl.mem_read;
  assign Id_Ex_MemWrite  = r_ctrl.mem_write;
  assign Id_Ex_MemToReg  = r_ctrl.mem_to_reg;
  assign Id_Ex_RegDst    = r_ctrl.reg_dst;
  assign Id_Ex_ReadSp    = r_ctrl.read_sp;
  assign Id_Ex_ALUSrc    = r_ctrl.alu_src;
  assign Id_Ex_Valid     = r_ctrl.valid;
  assign Id_Ex_ALUOp     = r_ctrl.alu_op;
  assign Stall_Count     = r_stall_cnt;

endmodule

// File: doc/id_ex_stage.md
# id_ex_stage

ID/EX pipeline register with integrated hazard detection for the eight-core processor datapath. It captures decoded operands and control from the ID stage. It produces the Id_Ex_* fields consumed by the forwarding unit and the EX stage, and it drives the PC/IF-ID stall and bubble controls. It covers two hazard classes that forwarding cannot resolve: load-use, and branch-in-ID operand dependencies.

## Interface
- DATA_W, 32, operand/immediate width
- REG_W, 5, register-index width
- Clk  in  1  rising-edge clock
- Rst  in  1  asynchronous, active-high reset
- If_Id_Rs, If_Id_Rt  in  REG_W  source indices of instruction in ID
- Id_Rd  in  REG_W  rd field of instruction in ID
- Id_ReadData1, Id_ReadData2, Id_Imm  in  DATA_W  ID operands
- Id_RegWrite, Id_MemRead, Id_MemWrite, Id_MemToReg, Id_RegDst, Id_ReadSp, Id_ALUSrc, Id_Branch, Id_Valid  in  1  ID control
- Id_ALUOp  in  4  ALU operation
- Ex_Mem_Rd  in  REG_W, Ex_Mem_MemRead  in  1  EX/MEM destination info
- Flush  in  1  squash instruction entering ID/EX
- Mem_Busy  in  1  data memory not ready; freeze entire pipeline
- Id_Ex_Rs, Id_Ex_Rt, Id_Ex_Dest  out  REG_W  registered indices; Dest = RegDst ? Rd : Rt
- Id_Ex_ReadData1, Id_Ex_ReadData2, Id_Ex_Imm  out  DATA_W
- Id_Ex_RegWrite, Id_Ex_MemRead, Id_Ex_MemWrite, Id_Ex_MemToReg, Id_Ex_RegDst, Id_Ex_ReadSp, Id_Ex_ALUSrc, Id_Ex_Valid  out  1
- Id_Ex_ALUOp  out  4
- PC_Write, If_Id_Write  out  1  0 = hold PC / IF-ID
- Stall_Count  out  16  saturating count of hazard-stall cycles

## Operation
- Hazard terms (combinational):
  - LU: Id_Ex_MemRead & Id_Ex_Dest≠0 & Id_Ex_Dest ∈ {If_Id_Rs, If_Id_Rt}.
  - BR_EX: Id_Branch & Id_Ex_RegWrite & Id_Ex_Dest≠0 & match.
  - BR_MEM: Id_Branch & Ex_Mem_MemRead & Ex_Mem_Rd≠0 & match.
  - Stall = Id_Valid & (LU | BR_EX | BR_MEM).
- FSM states:
  - RUN: normal operation.
  - BUBBLE: a stall was inserted this cycle.
  - FROZEN: Mem_Busy is active.
- Transitions:
  - Any state with Mem_Busy goes to FROZEN.
  - Otherwise, Stall goes to BUBBLE; else RUN.
  - BUBBLE has no special handling; re-evaluation each cycle produces the second stall cycle for a branch that depends on a load.
- Register update priority, highest first:
  - Rst: all outputs 0.
  - Mem_Busy: hold all fields.
  - Flush: load bubble.
  - Stall: load bubble.
  - Otherwise: capture ID inputs.
- Bubble: RegWrite, MemRead, MemWrite, ReadSp, Valid = 0 and Dest = 0. Data fields are don't-care; they are zeroed.
- PC_Write = If_Id_Write = ~(Stall | Mem_Busy). Flush alone does not hold the PC.
- Stall_Count increments on each cycle with Stall & ~Mem_Busy and saturates at 16'hFFFF. Rst clears it.
- Dest=0 is never treated as a hazard (r0 hardwired).

## Timing
- Register latency is 1 cycle: ID values appear on Id_Ex_* after the next rising Clk.
- PC_Write, If_Id_Write and Stall are combinational from the current Id_Ex_* and IF/ID fields, valid in the same cycle.
- Load-use: exactly 1 stall cycle.
- Branch after ALU op in ID/EX: 1 stall cycle.
- Branch after load in ID/EX: 2 stall cycles (BR_EX, then BR_MEM).
- Simultaneous events:
  - Flush and Stall together: bubble loaded, PC held.
  - Mem_Busy with anything: full freeze, Stall_Count not incremented.
- Reset is asynchronous and takes effect mid-cycle. All outputs go to 0 except PC_Write and If_Id_Write, which go to 1 once Id_Ex_* is 0. The FSM returns to RUN.

## Structure
- Shared package holds:
  - FSM state encoding (RUN=0, BUBBLE=1, FROZEN=2).
  - ALUOp width constant.
  - Bubble control-field constant.
- One sub-module: hazard_detect, pure combinational, producing LU, BR_EX, BR_MEM and Stall.
- The register, FSM and counter stay in id_ex_stage.

## Test plan
- lw writes r5 in ID/EX; add r6,r5,r7 in ID -> one bubble (Id_Ex_Valid=0), PC_Write=0 for 1 cycle, Stall_Count=1.
- add writes r3 in ID/EX; beq r3,r4 in ID -> 1 stall cycle, then the branch proceeds.
- lw writes r8; beq r8,r0 the next cycle -> 2 consecutive stall cycles, Stall_Count=2.
- lw writes r0; add reads r0 -> no stall.
- Mem_Busy=1 for 3 cycles during a load-use condition -> all outputs held, Stall_Count unchanged, then 1 bubble after release.
- Assert Rst mid-stall -> outputs immediately 0, state RUN, Stall_Count=0, PC_Write=1.
